operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Read side of the register file for the 5-stage pipeline.
- Drives rs1/rs2 selectors to the register file and receives data1/data2 back.
- Applies EX/MEM/WB forwarding and detects load-use hazards, inserting bubbles when one is found.
- Registers resolved operands into the ID/EX pipeline register for the execute stage.

Parameters:
- XLEN, 32, datapath width
- SEL, 5, register selector width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2, id_rd  in  SEL  decoded register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads the source
- id_regwen, id_is_load  in  1  decoded control
- rf_rs1, rf_rs2  out  SEL  register file read selectors
- rf_data1, rf_data2  in  XLEN  register file read data
- ex_valid, ex_regwen, ex_is_load  in  1  EX-stage control
- ex_rd  in  SEL  EX destination
- ex_result  in  XLEN  EX result
- mem_valid, mem_regwen  in  1  MEM-stage control
- mem_rd  in  SEL  MEM destination
- mem_result  in  XLEN  MEM result (load data or ALU result)
- wb_regwen  in  1  writeback enable
- wb_rd  in  SEL  writeback destination
- wb_data  in  XLEN  writeback data
- hold  in  1  downstream stall; freeze this stage
- flush  in  1  taken branch/jump; kill this stage
- stall  out  1  to IF/ID; freeze fetch and decode
- out_valid, out_regwen, out_is_load  out  1  ID/EX control
- out_rd  out  SEL  ID/EX destination
- out_op1, out_op2  out  XLEN  resolved operands
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Selectors are combinational: rf_rs1 = id_rs1, rf_rs2 = id_rs2.
- Operand resolution is combinational, per source, in this priority order:
  1. Index 0 gives 0.
  2. EX match (ex_valid & ex_regwen & !ex_is_load & ex_rd == idx) gives ex_result.
  3. MEM match (mem_valid & mem_regwen & mem_rd == idx) gives mem_result.
  4. WB match (wb_regwen & wb_rd == idx) gives wb_data.
  5. Otherwise rf_data1 / rf_data2.
  Matches on rd = 0 never forward.
- Hazard condition: id_valid & ex_valid & ex_is_load & ex_regwen & ex_rd != 0 & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- Combinational output: stall = hazard | hold.
- Posedge update, highest priority first:
  - rst: all out_* = 0, bubble_cnt = 0.
  - flush: out_valid = out_regwen = out_is_load = 0; other fields unchanged. Flush overrides hold and hazard.
  - hold: every register keeps its value, and bubble_cnt is not incremented even when hazard is also active.
  - hazard: out_valid = out_regwen = out_is_load = 0, which inserts the bubble. bubble_cnt increments, saturating at all-ones.
  - else: out_valid = id_valid. out_regwen = id_regwen & id_valid. out_is_load = id_is_load & id_valid. out_rd = id_rd. out_op1/out_op2 = resolved operands.
- Load-use latency: exactly one bubble per load-use pair. The next cycle the load sits in MEM and mem_result forwards.
- Forwarding never depends on the register-file write edge; the WB bypass covers same-cycle writeback.
- Reset asserted mid-stall clears everything. stall then reflects only the current inputs.

Test Plan:
- Reset: rst = 1 for 2 cycles with random inputs → all out_* = 0, bubble_cnt = 0. Then rf_data1 = 0x11, id_rs1 = 3, no matches, id_valid = 1 → out_op1 = 0x11, out_valid = 1.
- Forward priority: id_rs1 = 5 with EX (ex_result = 0xA), MEM (0xB) and WB (0xC) all targeting x5 → out_op1 = 0xA. Drop the EX match → 0xB. Drop MEM → 0xC. id_rs1 = 0 with all three matching x0 → out_op1 = 0.
- Load-use: ex_is_load, ex_rd = 7, id_rs2 = 7, id_use_rs2 = 1 → stall = 1 for 1 cycle, out_valid = 0, bubble_cnt = 1. Next cycle the MEM match gives out_op2 = mem_result.
- Unused source: same as the load-use case but id_use_rs2 = 0 → stall = 0, no bubble.
- Hold/flush: hold = 1 during a hazard → outputs frozen, bubble_cnt unchanged. Assert flush = 1 with hold = 1 → out_valid = 0 next edge.
- Saturation: force 0xFFFF hazards (or CNT_W = 4 with 20 hazards) → bubble_cnt sticks at all-ones.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register file read selectors, EX/MEM/WB forwarding,
// load-use bubble insertion and the ID/EX pipeline register.
module operand_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int SEL   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [SEL-1:0]   id_rs1,
  input  logic [SEL-1:0]   id_rs2,
  input  logic [SEL-1:0]   id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwen,
  input  logic             id_is_load,
  output logic [SEL-1:0]   rf_rs1,
  output logic [SEL-1:0]   rf_rs2,
  input  logic [XLEN-1:0]  rf_data1,
  input  logic [XLEN-1:0]  rf_data2,
  input  logic             ex_valid,
  input  logic             ex_regwen,
  input  logic             ex_is_load,
  input  logic [SEL-1:0]   ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_regwen,
  input  logic [SEL-1:0]   mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_regwen,
  input  logic [SEL-1:0]   wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic             out_regwen,
  output logic             out_is_load,
  output logic [SEL-1:0]   out_rd,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic            hazard;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  // Youngest producer wins; a load still in EX has no data yet, so it is skipped.
  function automatic logic [XLEN-1:0] resolve(input logic [SEL-1:0]  idx,
                                              input logic [XLEN-1:0] rf_val);
    if (idx == '0)
      return '0;
    else if (ex_valid && ex_regwen && !ex_is_load && (ex_rd == idx))
      return ex_result;
    else if (mem_valid && mem_regwen && (mem_rd == idx))
      return mem_result;
    else if (wb_regwen && (wb_rd == idx))
      return wb_data;
    else
      return rf_val;
  endfunction

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  always_comb begin
    op1 = resolve(id_rs1, rf_data1);
    op2 = resolve(id_rs2, rf_data2);
  end

  always_comb begin
    hazard = id_valid && ex_valid && ex_is_load && ex_regwen && (ex_rd != '0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
  end

  assign stall = hazard || hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_regwen  <= 1'b0;
      out_is_load <= 1'b0;
      out_rd      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_regwen  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (hold) begin
      // frozen: registers and bubble count keep their values
    end else if (hazard) begin
      out_valid   <= 1'b0;
      out_regwen  <= 1'b0;
      out_is_load <= 1'b0;
      if (bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      out_valid   <= id_valid;
      out_regwen  <= id_regwen && id_valid;
      out_is_load <= id_is_load && id_valid;
      out_rd      <= id_rd;
      out_op1     <= op1;
      out_op2     <= op2;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed vectors push expected
// ID/EX register contents, a monitor pops and compares after each clock edge.
module tb_operand_fetch_stage;
  localparam int XLEN  = 32;
  localparam int SEL   = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs1, id_use_rs2, id_regwen, id_is_load;
  logic [SEL-1:0]   id_rs1, id_rs2, id_rd;
  logic [SEL-1:0]   rf_rs1, rf_rs2;
  logic [XLEN-1:0]  rf_data1, rf_data2;
  logic             ex_valid, ex_regwen, ex_is_load;
  logic [SEL-1:0]   ex_rd;
  logic [XLEN-1:0]  ex_result;
  logic             mem_valid, mem_regwen;
  logic [SEL-1:0]   mem_rd;
  logic [XLEN-1:0]  mem_result;
  logic             wb_regwen;
  logic [SEL-1:0]   wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             hold, flush, stall;
  logic             out_valid, out_regwen, out_is_load;
  logic [SEL-1:0]   out_rd;
  logic [XLEN-1:0]  out_op1, out_op2;
  logic [CNT_W-1:0] bubble_cnt;

  typedef struct {
    logic             v;
    logic             rw;
    logic             ld;
    logic [SEL-1:0]   rd;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(XLEN), .SEL(SEL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwen(id_regwen), .id_is_load(id_is_load),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_regwen(mem_regwen), .mem_rd(mem_rd),
    .mem_result(mem_result),
    .wb_regwen(wb_regwen), .wb_rd(wb_rd), .wb_data(wb_data),
    .hold(hold), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_regwen(out_regwen), .out_is_load(out_is_load),
    .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2),
    .bubble_cnt(bubble_cnt)
  );

  // Monitor: the ID/EX register presents a new value every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== e.v || out_regwen !== e.rw || out_is_load !== e.ld ||
            out_rd !== e.rd || out_op1 !== e.op1 || out_op2 !== e.op2 ||
            bubble_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s: got v=%b rw=%b ld=%b rd=%0d op1=%h op2=%h cnt=%0d, want v=%b rw=%b ld=%b rd=%0d op1=%h op2=%h cnt=%0d",
                   e.name, out_valid, out_regwen, out_is_load, out_rd, out_op1, out_op2,
                   bubble_cnt, e.v, e.rw, e.ld, e.rd, e.op1, e.op2, e.cnt);
        end
      end
    end
  end

  task automatic push(input logic v, input logic rw, input logic ld,
                      input logic [SEL-1:0] rd, input logic [XLEN-1:0] op1,
                      input logic [XLEN-1:0] op2, input logic [CNT_W-1:0] cnt,
                      input string name);
    exp_t e;
    e.v = v; e.rw = rw; e.ld = ld; e.rd = rd;
    e.op1 = op1; e.op2 = op2; e.cnt = cnt; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic chk_stall(input logic want, input string name);
    #1;
    checks++;
    if (stall !== want) begin
      errors++;
      $display("FAIL %s: stall got %b want %b", name, stall, want);
    end
  endtask

  task automatic clear_in();
    rst = 0; hold = 0; flush = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_regwen = 0; id_is_load = 0;
    rf_data1 = 0; rf_data2 = 0;
    ex_valid = 0; ex_regwen = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_valid = 0; mem_regwen = 0; mem_rd = 0; mem_result = 0;
    wb_regwen = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Common decoded instruction: x3 + x4 -> x9
  task automatic base_id();
    clear_in();
    id_valid = 1; id_regwen = 1; id_rd = 9;
    id_rs1 = 3; id_rs2 = 4; id_use_rs1 = 1; id_use_rs2 = 1;
    rf_data1 = 32'h11; rf_data2 = 32'h22;
  endtask

  initial begin
    clear_in();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1;
      id_valid = 1'($urandom); id_rs1 = SEL'($urandom); id_rs2 = SEL'($urandom);
      id_rd = SEL'($urandom); id_regwen = 1'($urandom); id_is_load = 1'($urandom);
      rf_data1 = $urandom; rf_data2 = $urandom;
      ex_valid = 1'($urandom); ex_rd = SEL'($urandom); ex_result = $urandom;
      mem_valid = 1'($urandom); mem_result = $urandom; wb_data = $urandom;
      flush = 1'($urandom); hold = 1'($urandom);
      push(0, 0, 0, 0, 0, 0, 0, "reset");
    end

    @(negedge clk); base_id(); chk_stall(0, "plain_stall");
    push(1, 1, 0, 9, 32'h11, 32'h22, 0, "plain_read");

    @(negedge clk); base_id(); id_rs1 = 5;
    ex_valid = 1; ex_regwen = 1; ex_rd = 5; ex_result = 32'hA;
    mem_valid = 1; mem_regwen = 1; mem_rd = 5; mem_result = 32'hB;
    wb_regwen = 1; wb_rd = 5; wb_data = 32'hC;
    chk_stall(0, "fwd_stall");
    push(1, 1, 0, 9, 32'hA, 32'h22, 0, "fwd_ex");

    @(negedge clk); ex_valid = 0; #1;
    push(1, 1, 0, 9, 32'hB, 32'h22, 0, "fwd_mem");
    @(negedge clk); mem_valid = 0; #1;
    push(1, 1, 0, 9, 32'hC, 32'h22, 0, "fwd_wb");
    @(negedge clk); wb_regwen = 0; #1;
    push(1, 1, 0, 9, 32'h11, 32'h22, 0, "fwd_none");

    @(negedge clk); base_id(); id_rs1 = 0; id_rd = 10; id_is_load = 1; rf_data1 = 32'h55;
    ex_valid = 1; ex_regwen = 1; ex_rd = 0; ex_result = 32'hA;
    mem_valid = 1; mem_regwen = 1; mem_rd = 0; mem_result = 32'hB;
    wb_regwen = 1; wb_rd = 0; wb_data = 32'hC;
    chk_stall(0, "x0_stall");
    push(1, 1, 1, 10, 32'h0, 32'h22, 0, "x0_zero");

    // Load in EX writing x7, decode reads x7 as rs2.
    @(negedge clk); base_id(); id_rd = 8; id_rs2 = 7; rf_data2 = 32'h77;
    ex_valid = 1; ex_regwen = 1; ex_is_load = 1; ex_rd = 7; ex_result = 32'hDEAD;
    chk_stall(1, "loaduse_stall");
    push(0, 0, 0, 10, 32'h0, 32'h22, 1, "loaduse_bubble");

    @(negedge clk); ex_valid = 0; ex_regwen = 0; ex_is_load = 0;
    mem_valid = 1; mem_regwen = 1; mem_rd = 7; mem_result = 32'h1234;
    chk_stall(0, "loaduse_release");
    push(1, 1, 0, 8, 32'h11, 32'h1234, 1, "loaduse_memfwd");

    @(negedge clk); mem_valid = 0; mem_regwen = 0;
    ex_valid = 1; ex_regwen = 1; ex_is_load = 1; ex_rd = 7; id_use_rs2 = 0;
    chk_stall(0, "unused_stall");
    push(1, 1, 0, 8, 32'h11, 32'h77, 1, "unused_nobubble");

    @(negedge clk); id_use_rs2 = 1; hold = 1; rf_data1 = 32'h99;
    chk_stall(1, "hold_stall");
    push(1, 1, 0, 8, 32'h11, 32'h77, 1, "hold_frozen");

    @(negedge clk); flush = 1;
    chk_stall(1, "holdflush_stall");
    push(0, 0, 0, 8, 32'h11, 32'h77, 1, "flush_over_hold");

    @(negedge clk); hold = 0;
    chk_stall(1, "flush_haz_stall");
    push(0, 0, 0, 8, 32'h11, 32'h77, 1, "flush_over_hazard");

    @(negedge clk); flush = 0; hold = 1; rst = 1;
    chk_stall(1, "rst_stall_comb");
    push(0, 0, 0, 0, 0, 0, 0, "reset_midstall");

    @(negedge clk); rst = 0; hold = 0;
    for (int i = 1; i <= 20; i++) begin
      push(0, 0, 0, 0, 0, 0, (i >= 15) ? CNT_W'(15) : CNT_W'(i), "saturate");
      @(negedge clk);
    end

    base_id(); id_valid = 0; id_rd = 3; id_is_load = 1;
    wb_regwen = 1; wb_rd = 4; wb_data = 32'hCAFE;
    chk_stall(0, "invalid_stall");
    push(0, 0, 0, 3, 32'h11, 32'hCAFE, 15, "invalid_gated");

    begin
      int budget = 10;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk); #2; budget--;
      end
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
